// File: rtl/requant_param_ctrl.sv
// requant_param_ctrl: round-robin sharing of the requantization scale ROM.
// Optional one-entry result cache enabled by define REQUANT_CTRL_CACHE_EN.
module requant_param_ctrl #(
    parameter int NUM_REQ     = 2,
    parameter int NUM_LAYERS  = 6,
    parameter int MULT_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 6,
    localparam int LAYER_W    = $clog2(NUM_LAYERS),
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LAYER_W-1:0] req_layer,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rom_valid,
    output logic [LAYER_W-1:0]         rom_layer_idx,
    input  logic [MULT_WIDTH-1:0]      rom_mult,
    input  logic [SHIFT_WIDTH-1:0]     rom_shift,
    output logic                       resp_valid,
    output logic [ID_W-1:0]            resp_id,
    output logic [MULT_WIDTH-1:0]      resp_mult,
    output logic [SHIFT_WIDTH-1:0]     resp_shift,
    output logic                       resp_err,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [LAYER_W:0] LAYERS = (LAYER_W + 1)'(NUM_LAYERS);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic                   rom_valid_q, rom_valid_d;
    logic [LAYER_W-1:0]     rom_idx_q, rom_idx_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]        resp_id_q, resp_id_d;
    logic                   resp_err_q, resp_err_d;
    logic [MULT_WIDTH-1:0]  mult_q, mult_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;

    logic [LAYER_W-1:0]     layer_arr [NUM_REQ];
    logic                   win_found;
    logic [ID_W-1:0]        win_id;
    logic [ID_W-1:0]        cand;
    logic [LAYER_W-1:0]     win_layer;
    logic                   win_oor;
    logic                   hit;

`ifdef REQUANT_CTRL_CACHE_EN
    logic                   cache_vld_q, cache_vld_d;
    logic [LAYER_W-1:0]     tag_q, tag_d;
    logic [LAYER_W-1:0]     layer_q, layer_d;
    logic [MULT_WIDTH-1:0]  cmult_q, cmult_d;
    logic [SHIFT_WIDTH-1:0] cshift_q, cshift_d;

    assign hit = cache_vld_q && (tag_q == win_layer);
`else
    assign hit = 1'b0;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_layer
        assign layer_arr[g] = req_layer[g*LAYER_W +: LAYER_W];
    end

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign win_layer = layer_arr[win_id];
    assign win_oor   = {1'b0, win_layer} >= LAYERS;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        rom_valid_d  = 1'b0;
        rom_idx_d    = '0;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
        mult_d       = mult_q;
        shift_d      = shift_q;
        gnt          = '0;
`ifdef REQUANT_CTRL_CACHE_EN
        cache_vld_d  = cache_vld_q;
        tag_d        = tag_q;
        layer_d      = layer_q;
        cmult_d      = cmult_q;
        cshift_d     = cshift_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt[win_id] = 1'b1;
                    id_d        = win_id;
                    rr_ptr_d    = ID_W'((int'(win_id) + 1) % NUM_REQ);
`ifdef REQUANT_CTRL_CACHE_EN
                    layer_d     = win_layer;
`endif
                    if (win_oor) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_id_d    = win_id;
                        resp_err_d   = 1'b1;
                        mult_d       = '0;
                        shift_d      = '0;
                    end else if (hit) begin
`ifdef REQUANT_CTRL_CACHE_EN
                        mult_d       = cmult_q;
                        shift_d      = cshift_q;
`endif
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_id_d    = win_id;
                        resp_err_d   = 1'b0;
                    end else begin
                        state_d      = ISSUE;
                        rom_valid_d  = 1'b1;
                        rom_idx_d    = win_layer;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // ROM data is only valid during this cycle.
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_id_d    = id_q;
                resp_err_d   = 1'b0;
                mult_d       = rom_mult;
                shift_d      = rom_shift;
`ifdef REQUANT_CTRL_CACHE_EN
                cache_vld_d  = 1'b1;
                tag_d        = layer_q;
                cmult_d      = rom_mult;
                cshift_d     = rom_shift;
`endif
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            rom_valid_q  <= 1'b0;
            rom_idx_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
            mult_q       <= '0;
            shift_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            rom_valid_q  <= rom_valid_d;
            rom_idx_q    <= rom_idx_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
            mult_q       <= mult_d;
            shift_q      <= shift_d;
        end
    end

`ifdef REQUANT_CTRL_CACHE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_vld_q <= 1'b0;
            tag_q       <= '0;
            layer_q     <= '0;
            cmult_q     <= '0;
            cshift_q    <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
            tag_q       <= tag_d;
            layer_q     <= layer_d;
            cmult_q     <= cmult_d;
            cshift_q    <= cshift_d;
        end
    end
`endif

    assign rom_valid     = rom_valid_q;
    assign rom_layer_idx = rom_idx_q;
    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_mult     = mult_q;
    assign resp_shift    = shift_q;
    assign resp_err      = resp_err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_requant_param_ctrl.sv
// tb_requant_param_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level model of arbitration, latency and ROM data.
module tb_requant_param_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [5:0]  req_layer;
    logic [1:0]  gnt;
    logic        rom_valid;
    logic [2:0]  rom_layer_idx;
    logic [31:0] rom_mult;
    logic [5:0]  rom_shift;
    logic        resp_valid;
    logic        resp_id;
    logic [31:0] resp_mult;
    logic [5:0]  resp_shift;
    logic        resp_err;
    logic        busy;

    int ncmp = 0;
    int nfail = 0;

    logic [31:0] rom_m [8];
    logic [5:0]  rom_s [8];

    logic [1:0]  o_gnt;
    int          o_lat;
    int          o_nrom;
    logic [2:0]  o_idx;
    logic        o_id;
    logic [31:0] o_mult;
    logic [5:0]  o_shift;
    logic        o_err;

    requant_param_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_layer     (req_layer),
        .gnt           (gnt),
        .rom_valid     (rom_valid),
        .rom_layer_idx (rom_layer_idx),
        .rom_mult      (rom_mult),
        .rom_shift     (rom_shift),
        .resp_valid    (resp_valid),
        .resp_id       (resp_id),
        .resp_mult     (resp_mult),
        .resp_shift    (resp_shift),
        .resp_err      (resp_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read ROM: data one cycle after the strobe, zero otherwise.
    always @(posedge clk) begin
        rom_mult  <= rom_valid ? rom_m[rom_layer_idx] : 32'd0;
        rom_shift <= rom_valid ? rom_s[rom_layer_idx] : 6'd0;
    end

    task automatic do_reset();
        req       = '0;
        req_layer = '0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Single request from one requester; observations land in o_*.
    task automatic one_txn(input int id, input logic [2:0] lay);
        o_lat  = -1;
        o_nrom = 0;
        o_idx  = '0;
        o_id   = 1'b0;
        o_err  = 1'b0;
        o_mult = '0;
        o_shift = '0;
        @(posedge clk); #1;
        req = (id == 0) ? 2'b01 : 2'b10;
        if (id == 0) req_layer[2:0] = lay;
        else req_layer[5:3] = lay;
        #1;
        o_gnt = gnt;
        for (int k = 1; k <= 8 && o_lat < 0; k++) begin
            @(posedge clk); #1;
            req = '0;
            #1;
            if (rom_valid) begin
                o_nrom++;
                o_idx = rom_layer_idx;
            end
            if (resp_valid) begin
                o_lat   = k;
                o_id    = resp_id;
                o_mult  = resp_mult;
                o_shift = resp_shift;
                o_err   = resp_err;
            end
        end
    endtask

    task automatic test_reset();
        logic [47:0] allo;
        req       = '0;
        req_layer = '0;
        reset     = 1'b1;
        #2;
        allo = {gnt, rom_valid, rom_layer_idx, resp_valid, resp_id,
                resp_mult, resp_shift, resp_err, busy};
        ncmp++;
        if (allo !== 48'd0) begin
            nfail++;
            $display("FAIL reset_outs got %h exp 0", allo);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #2;
        allo = {gnt, rom_valid, rom_layer_idx, resp_valid, resp_id,
                resp_mult, resp_shift, resp_err, busy};
        ncmp++;
        if (allo !== 48'd0) begin
            nfail++;
            $display("FAIL reset_idle got %h exp 0", allo);
        end
    endtask

    task automatic test_basic();
        do_reset();
        @(posedge clk); #1;
        req = 2'b01;
        req_layer[2:0] = 3'd3;
        #1;
        ncmp++;
        if ({gnt, rom_valid, busy} !== {2'b01, 1'b0, 1'b0}) begin
            nfail++;
            $display("FAIL basic_c0 got %b exp 0100", {gnt, rom_valid, busy});
        end
        @(posedge clk); #1;
        req = '0;
        #1;
        ncmp++;
        if ({gnt, rom_valid, rom_layer_idx, busy} !== {2'b00, 1'b1, 3'd3, 1'b1}) begin
            nfail++;
            $display("FAIL basic_c1 got %b exp 0010111",
                     {gnt, rom_valid, rom_layer_idx, busy});
        end
        @(posedge clk); #2;
        ncmp++;
        if ({rom_valid, resp_valid, busy} !== 3'b001) begin
            nfail++;
            $display("FAIL basic_c2 got %b exp 001", {rom_valid, resp_valid, busy});
        end
        @(posedge clk); #2;
        ncmp++;
        if ({resp_valid, resp_id, resp_mult, resp_shift, resp_err}
            !== {1'b1, 1'b0, 32'h4000_0000, 6'd7, 1'b0}) begin
            nfail++;
            $display("FAIL basic_resp got v%b id%b m%h s%0d e%b exp v1 id0 m40000000 s7 e0",
                     resp_valid, resp_id, resp_mult, resp_shift, resp_err);
        end
        @(posedge clk); #2;
        ncmp++;
        if ({resp_valid, busy, resp_mult} !== {2'b00, 32'h4000_0000}) begin
            nfail++;
            $display("FAIL basic_hold got v%b b%b m%h exp v0 b0 m40000000",
                     resp_valid, busy, resp_mult);
        end
    endtask

    task automatic test_rr_alternate();
        logic [1:0]  eg;
        logic        ev;
        logic        eid;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            req       = 2'b11;
            req_layer = {3'd4, 3'd1};
            #1;
            eg  = (k % 4 != 0) ? 2'b00 : (((k / 4) % 2 == 0) ? 2'b01 : 2'b10);
            ev  = (k % 4 == 3);
            eid = ((k / 4) % 2) == 1;
            ncmp++;
            if ({gnt, resp_valid} !== {eg, ev}) begin
                nfail++;
                $display("FAIL rr_c%0d got g%b v%b exp g%b v%b", k, gnt, resp_valid, eg, ev);
            end
            if (ev) begin
                ncmp++;
                if ({resp_id, resp_mult} !== {eid, rom_m[eid ? 4 : 1]}) begin
                    nfail++;
                    $display("FAIL rr_resp%0d got id%b m%h exp id%b m%h", k,
                             resp_id, resp_mult, eid, rom_m[eid ? 4 : 1]);
                end
            end
        end
        req = '0;
    endtask

    task automatic test_out_of_range();
        do_reset();
        one_txn(0, 3'd3);
        one_txn(1, 3'd6);
        ncmp++;
        if ({o_gnt, o_nrom, o_lat, o_id, o_err, o_mult, o_shift}
            !== {2'b10, 32'd0, 32'd1, 1'b1, 1'b1, 32'd0, 6'd0}) begin
            nfail++;
            $display("FAIL oor6 got g%b rom%0d lat%0d id%b e%b m%h s%0d exp g10 rom0 lat1 id1 e1 m0 s0",
                     o_gnt, o_nrom, o_lat, o_id, o_err, o_mult, o_shift);
        end
        one_txn(0, 3'd7);
        ncmp++;
        if ({o_nrom, o_lat, o_id, o_err, o_mult, o_shift}
            !== {32'd0, 32'd1, 1'b0, 1'b1, 32'd0, 6'd0}) begin
            nfail++;
            $display("FAIL oor7 got rom%0d lat%0d id%b e%b m%h s%0d exp rom0 lat1 id0 e1 m0 s0",
                     o_nrom, o_lat, o_id, o_err, o_mult, o_shift);
        end
        one_txn(1, 3'd5);
        ncmp++;
        if ({o_lat, o_err, o_mult, o_idx} !== {32'd3, 1'b0, rom_m[5], 3'd5}) begin
            nfail++;
            $display("FAIL oor_after got lat%0d e%b m%h idx%0d exp lat3 e0 m%h idx5",
                     o_lat, o_err, o_mult, o_idx, rom_m[5]);
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] allo;
        bit          seen;
        do_reset();
        one_txn(0, 3'd1);
        @(posedge clk); #1;
        req = 2'b01;
        req_layer[2:0] = 3'd5;
        #1;
        ncmp++;
        if (gnt !== 2'b01) begin
            nfail++;
            $display("FAIL rmid_gnt got %b exp 01", gnt);
        end
        @(posedge clk); #1;
        req = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        allo = {gnt, rom_valid, rom_layer_idx, resp_valid, resp_id,
                resp_mult, resp_shift, resp_err, busy};
        ncmp++;
        if (allo !== 48'd0) begin
            nfail++;
            $display("FAIL rmid_outs got %h exp 0", allo);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #2;
            if (resp_valid || busy) seen = 1'b1;
        end
        ncmp++;
        if (seen !== 1'b0) begin
            nfail++;
            $display("FAIL rmid_noresp got %b exp 0", seen);
        end
        one_txn(1, 3'd2);
        ncmp++;
        if ({o_gnt, o_lat, o_nrom, o_idx, o_id, o_mult, o_shift, o_err}
            !== {2'b10, 32'd3, 32'd1, 3'd2, 1'b1, rom_m[2], rom_s[2], 1'b0}) begin
            nfail++;
            $display("FAIL rmid_new got g%b lat%0d rom%0d id%b m%h exp g10 lat3 rom1 id1 m%h",
                     o_gnt, o_lat, o_nrom, o_id, o_mult, rom_m[2]);
        end
    endtask

    task automatic test_cache();
        int elat;
        int enrom;
        do_reset();
        one_txn(0, 3'd2);
        ncmp++;
        if ({o_lat, o_nrom, o_mult, o_shift} !== {32'd3, 32'd1, rom_m[2], rom_s[2]}) begin
            nfail++;
            $display("FAIL cache_first got lat%0d rom%0d m%h exp lat3 rom1 m%h",
                     o_lat, o_nrom, o_mult, rom_m[2]);
        end
`ifdef REQUANT_CTRL_CACHE_EN
        elat  = 1;
        enrom = 0;
`else
        elat  = 3;
        enrom = 1;
`endif
        one_txn(0, 3'd2);
        ncmp++;
        if ({o_lat, o_nrom, o_mult, o_shift, o_err}
            !== {elat, enrom, rom_m[2], rom_s[2], 1'b0}) begin
            nfail++;
            $display("FAIL cache_second got lat%0d rom%0d m%h s%0d exp lat%0d rom%0d m%h s%0d",
                     o_lat, o_nrom, o_mult, o_shift, elat, enrom, rom_m[2], rom_s[2]);
        end
        one_txn(1, 3'd4);
        ncmp++;
        if ({o_lat, o_nrom, o_idx, o_mult} !== {32'd3, 32'd1, 3'd4, rom_m[4]}) begin
            nfail++;
            $display("FAIL cache_other got lat%0d rom%0d idx%0d m%h exp lat3 rom1 idx4 m%h",
                     o_lat, o_nrom, o_idx, o_mult, rom_m[4]);
        end
    endtask

    task automatic test_pending();
        logic [1:0] eg;
        logic       ev;
        do_reset();
        @(posedge clk); #1;
        req = 2'b01;
        req_layer = {3'd5, 3'd1};
        #1;
        ncmp++;
        if (gnt !== 2'b01) begin
            nfail++;
            $display("FAIL pend_g0 got %b exp 01", gnt);
        end
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            req = (k <= 4) ? 2'b10 : 2'b00;
            #1;
            eg = (k == 4) ? 2'b10 : 2'b00;
            ev = (k == 3) || (k == 7);
            ncmp++;
            if ({gnt, resp_valid} !== {eg, ev}) begin
                nfail++;
                $display("FAIL pend_c%0d got g%b v%b exp g%b v%b", k, gnt, resp_valid, eg, ev);
            end
            if (ev) begin
                ncmp++;
                if ({resp_id, resp_mult} !== {k == 7, rom_m[(k == 7) ? 5 : 1]}) begin
                    nfail++;
                    $display("FAIL pend_resp%0d got id%b m%h exp id%b m%h", k, resp_id,
                             resp_mult, k == 7, rom_m[(k == 7) ? 5 : 1]);
                end
            end
        end
    endtask

    // Transaction-level model: a free controller grants the first pending
    // requester from rr; misses answer 3 cycles later, skips 1 cycle later.
    task automatic test_random();
        bit          pend [2];
        logic [2:0]  lay [2];
        int          free_at, rr, g_cyc, r_cyc, rom_cyc;
        logic [2:0]  rom_i;
        logic        exp_id, exp_err;
        logic [31:0] h_mult, p_mult, cm;
        logic [5:0]  h_shift, p_shift, cs;
        bit          cv;
        logic [2:0]  ctag;
        do_reset();
        free_at = 0; rr = 0;
        g_cyc = -10; r_cyc = -10; rom_cyc = -10;
        rom_i = '0; exp_id = 1'b0; exp_err = 1'b0;
        h_mult = '0; h_shift = '0; p_mult = '0; p_shift = '0;
        cv = 1'b0; ctag = '0; cm = '0; cs = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        lay[0] = '0; lay[1] = '0;
        for (int c = 0; c < 400; c++) begin
            logic [1:0] eg;
            logic [5:0] ectl;
            int         w;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i] = 1'b1;
                    lay[i]  = 3'($urandom_range(7));
                end
            end
            req       = {pend[1], pend[0]};
            req_layer = {lay[1], lay[0]};
            #1;
            eg = 2'b00;
            w  = -1;
            if (c >= free_at) begin
                for (int k = 0; k < 2; k++)
                    if (w < 0 && pend[(rr + k) % 2]) w = (rr + k) % 2;
            end
            if (w >= 0) begin
                eg[w]   = 1'b1;
                pend[w] = 1'b0;
                rr      = (w + 1) % 2;
                g_cyc   = c;
                exp_id  = (w == 1);
                if (lay[w] >= 3'd6) begin
                    r_cyc   = c + 1;
                    exp_err = 1'b1;
                    p_mult  = '0;
                    p_shift = '0;
`ifdef REQUANT_CTRL_CACHE_EN
                end else if (cv && ctag == lay[w]) begin
                    r_cyc   = c + 1;
                    exp_err = 1'b0;
                    p_mult  = cm;
                    p_shift = cs;
`endif
                end else begin
                    rom_cyc = c + 1;
                    rom_i   = lay[w];
                    r_cyc   = c + 3;
                    exp_err = 1'b0;
                    p_mult  = rom_m[lay[w]];
                    p_shift = rom_s[lay[w]];
                    cv = 1'b1; ctag = lay[w]; cm = p_mult; cs = p_shift;
                end
                free_at = r_cyc + 1;
            end
            if (c == r_cyc) begin
                h_mult  = p_mult;
                h_shift = p_shift;
            end
            ectl = {eg, c == rom_cyc, c == r_cyc, (c > g_cyc) && (c <= r_cyc)} ;
            ncmp++;
            if ({gnt, rom_valid, resp_valid, busy} !== ectl[4:0]) begin
                nfail++;
                $display("FAIL rnd_ctl c=%0d got %b exp %b", c,
                         {gnt, rom_valid, resp_valid, busy}, ectl[4:0]);
            end
            ncmp++;
            if ({rom_layer_idx, resp_mult, resp_shift}
                !== {(c == rom_cyc) ? rom_i : 3'd0, h_mult, h_shift}) begin
                nfail++;
                $display("FAIL rnd_data c=%0d got idx%0d m%h s%h exp idx%0d m%h s%h", c,
                         rom_layer_idx, resp_mult, resp_shift,
                         (c == rom_cyc) ? rom_i : 3'd0, h_mult, h_shift);
            end
            if (c == r_cyc) begin
                ncmp++;
                if ({resp_id, resp_err} !== {exp_id, exp_err}) begin
                    nfail++;
                    $display("FAIL rnd_resp c=%0d got id%b e%b exp id%b e%b", c,
                             resp_id, resp_err, exp_id, exp_err);
                end
            end
        end
        req = '0;
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_layer = '0;
        for (int i = 0; i < 8; i++) begin
            rom_m[i] = $urandom | 32'h0000_0100;
            rom_s[i] = 6'($urandom_range(63));
        end
        rom_m[3] = 32'h4000_0000;
        rom_s[3] = 6'd7;
        test_reset();
        test_basic();
        test_rr_alternate();
        test_out_of_range();
        test_reset_mid();
        test_cache();
        test_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
